// File: rtl/aes_key_expansion_if.sv
// Request/response bundle for the AES-128 single-round key schedule step.
interface aes_key_expansion_if;
  logic         in_valid;
  logic [3:0]   num_round;
  logic [127:0] key_in;
  logic [127:0] key_out;
  logic         out_valid;

  // Caller side: drives the round request, consumes the next key.
  modport master (output in_valid, num_round, key_in, input key_out, out_valid);
  // Key schedule side.
  modport slave  (input in_valid, num_round, key_in, output key_out, out_valid);
endinterface

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule step: next round key from current key and round index,
// registered once. Four independent S-box lookups, no internal round counter.

// Forward AES S-box, one byte, pure table lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];
endmodule

module aes_key_expansion (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_key_expansion_if.slave    bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][31:0] w;
  logic [NUM_LANES-1:0][7:0]  rot_w;
  logic [NUM_LANES-1:0][7:0]  sub_w;
  logic [7:0]                 rcon;
  logic [31:0]                temp;
  logic [NUM_LANES-1:0][31:0] n;

  logic [127:0] key_d, key_q;
  logic         vld_d, vld_q;

  // w[3] is word 0 (MSB), w[0] is word 3.
  assign w = bus.key_in;

  // RotWord on word 3: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  assign rot_w = {w[0][23:0], w[0][31:24]};

  // One S-box per byte lane.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[i]), .y(sub_w[i]));
  end

  // Round constant; indices past the last AES-128 round contribute nothing.
  always_comb begin
    rcon = 8'h00;
    case (bus.num_round)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Word chain: each new word folds in the previous new word.
  always_comb begin
    temp = sub_w ^ {rcon, 24'h000000};
    n[3] = w[3] ^ temp;
    n[2] = w[2] ^ n[3];
    n[1] = w[1] ^ n[2];
    n[0] = w[0] ^ n[1];
  end

  // Capture a new key only on accepted input; the valid flag is a one-cycle pulse.
  always_comb begin
    key_d = key_q;
    vld_d = 1'b0;
    if (bus.in_valid) begin
      key_d = n;
      vld_d = 1'b1;
    end
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      vld_q <= 1'b0;
    end else begin
      key_q <= key_d;
      vld_q <= vld_d;
    end
  end

  assign bus.key_out   = key_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: FIPS-197 vectors plus random requests checked
// against a model that builds the S-box from GF(2^8) arithmetic.
module tb_aes_key_expansion;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  aes_key_expansion_if bus ();

  aes_key_expansion dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic [127:0] exp_key = '0;
  logic         exp_vld = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Multiplicative inverse (a^254) followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] c = 8'h01;
    if (r >= 10) return 8'h00;
    for (int i = 0; i < r; i++) c = xt(c);
    return c;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
    logic [31:0] wd [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) wd[i] = k[127-32*i -: 32];
    t = {sbox(wd[3][23:16]), sbox(wd[3][15:8]), sbox(wd[3][7:0]), sbox(wd[3][31:24])};
    t = t ^ {rcon_of(r), 24'h0};
    wd[0] = wd[0] ^ t;
    for (int i = 1; i < 4; i++) wd[i] = wd[i] ^ wd[i-1];
    return {wd[0], wd[1], wd[2], wd[3]};
  endfunction

  // Drive one cycle from a negedge, then check the registered result at the next negedge.
  task automatic step(input logic v, input logic [127:0] k, input int r, input string tag);
    bus.in_valid  = v;
    bus.key_in    = k;
    bus.num_round = r[3:0];
    @(negedge clk);
    if (v) begin
      exp_key = next_key(k, r);
      exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    chk({tag, ".key"}, bus.key_out, exp_key);
    chk({tag, ".vld"}, {127'd0, bus.out_valid}, {127'd0, exp_vld});
  endtask

  logic [127:0] k;

  initial begin
    bus.in_valid  = 1'b1;
    bus.key_in    = CIPHER_KEY;
    bus.num_round = 4'd0;

    // Reset: outputs clear and inputs ignored even with in_valid high across edges.
    #1;
    chk("rst.key", bus.key_out, 128'h0);
    chk("rst.vld", {127'd0, bus.out_valid}, 128'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ign.key", bus.key_out, 128'h0);
    chk("rst_ign.vld", {127'd0, bus.out_valid}, 128'h0);
    rst_n = 1'b1;

    // FIPS-197 round 1, then out_valid drops.
    step(1'b1, CIPHER_KEY, 0, "r1");
    chk("r1.fips", bus.key_out, RK1);
    step(1'b0, CIPHER_KEY, 0, "r1_idle");

    // Full chained schedule.
    k = CIPHER_KEY;
    for (int r = 0; r < 10; r++) begin
      step(1'b1, k, r, $sformatf("chain%0d", r));
      k = bus.key_out;
      if (r == 1) chk("chain.rk2", k, RK2);
    end
    chk("chain.rk10", k, RK10);

    // Zero key.
    step(1'b1, 128'h0, 0, "zero");
    chk("zero.fips", bus.key_out, 128'h62636363626363636263636362636363);

    // Hold for 5 idle cycles.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, $urandom(), $urandom_range(15), "hold");
      chk("hold.const", bus.key_out, 128'h62636363626363636263636362636363);
    end

    // Async reset mid-chain, between edges.
    k = CIPHER_KEY;
    for (int r = 0; r < 5; r++) begin
      step(1'b1, k, r, "pre_rst");
      k = bus.key_out;
    end
    bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.key", bus.key_out, 128'h0);
    chk("arst.vld", {127'd0, bus.out_valid}, 128'h0);
    exp_key = '0;
    exp_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, CIPHER_KEY, 0, "post_rst");
    chk("post_rst.fips", bus.key_out, RK1);

    // Out-of-range index: Rcon treated as zero.
    step(1'b1, CIPHER_KEY, 12, "oor");
    chk("oor.fips", bus.key_out, 128'ha1fafe1789542cb122a339392b6c7605);

    // Random requests, all indices, random gaps.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(3) != 0), {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(15), "rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
